i2c_slave_rx: RTL and testbench
===============================

# i2c_slave_rx

Write-only I2C slave receiver that consumes the bus traffic produced by the team's `i2c_master`. It detects START and STOP conditions and deserialises the address byte, acknowledging only its own address with a write request. It then receives data bytes MSB-first, ACKs each one, and presents them on a parallel byte port with a one-cycle valid strobe. It sits directly downstream of the master on the shared SCL/SDA lines. It is oversampled by the system clock and never drives SCL (no clock stretching).

## Interface
Parameters:
- SLAVE_ADDR, 7'h50, 7-bit address this slave ACKs.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  system clock; must be at least 8x the SCL frequency.
- rst  input  1  synchronous active-high reset.
- scl  input  1  raw bus SCL, asynchronous to clk.
- sda_in  input  1  raw bus SDA level, asynchronous to clk.
- sda_pull_low  output  1  1 = pull SDA low for ACK; 0 = release. The bus line is the wired-AND `sda_in & ~sda_pull_low`.
- rx_data  output  8  last complete data byte received.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- addr_match  output  1  high from the ACKed address byte until the next STOP or START.
- stop_seen  output  1  one-cycle pulse on each detected STOP.
- byte_count  output  8  data bytes received in the current transaction; saturates at 255.

## Operation
- Input conditioning: scl and sda_in each pass through a 2-flop synchroniser, giving scl_s and sda_s. A third register holds the previous values for edge detection.
- Events, all evaluated on synchronised signals:
  - SCL rise: scl_s 0->1.
  - SCL fall: scl_s 1->0.
  - START: sda_s 1->0 while scl_s=1.
  - STOP: sda_s 0->1 while scl_s=1.
- State machine: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
- IDLE: waits for START -> ADDR. Bit counter = 0, shift register cleared.
- ADDR: on each SCL rise, shift sda_s into the LSB. After the 8th bit, compare shift[7:1] against SLAVE_ADDR and check shift[0] (R/W).
  - Match and R/W=0: go to ADDR_ACK and set addr_match=1.
  - Anything else: go to IGNORE with sda_pull_low held at 0, which NACKs by leaving the line released.
- ADDR_ACK / DATA_ACK:
  - On the first SCL fall after entering the state, assert sda_pull_low=1.
  - Keep it asserted through the 9th SCL high phase.
  - On the following SCL fall, deassert it and go to DATA with the bit counter cleared.
- DATA: on each SCL rise, shift sda_s in. On the 8th bit, in the same cycle:
  - load rx_data with the full byte,
  - pulse rx_valid,
  - increment byte_count (saturating),
  - go to DATA_ACK.
- IGNORE: passive. Drives nothing and waits for START or STOP.
- START in any state, including a repeated START mid-byte or mid-ACK:
  - go to ADDR; clear the bit counter, byte_count and addr_match;
  - sda_pull_low=0 immediately.
- STOP in any state:
  - go to IDLE and pulse stop_seen;
  - clear addr_match and sda_pull_low;
  - discard any partial byte (no rx_valid);
  - byte_count is retained until the next START.
- START/STOP take priority over SCL-edge processing in the same cycle.
- sda_pull_low is forced to 0 in every state except ADDR_ACK and DATA_ACK.

## Timing
- Reset values: sda_pull_low=0, rx_data=8'h00, rx_valid=0, addr_match=0, stop_seen=0, byte_count=0; state=IDLE; synchroniser flops reset to 1 (idle bus).
- Reset mid-transaction: the next cycle is IDLE with all outputs at reset values. The block ignores the bus until a fresh START.
- Event detection latency: 3 clk from a raw pin transition (2 sync + 1 edge register).
- rx_valid and the rx_data update occur in the same cycle, 3 clk after the raw 8th-bit SCL rise. rx_valid is exactly 1 clk wide.
- sda_pull_low asserts 3 clk after the raw SCL fall ending bit 8, and deasserts 3 clk after the raw SCL fall ending bit 9.
- addr_match rises in the same cycle as the ADDR->ADDR_ACK transition.
- stop_seen pulses 3 clk after the raw SDA rise.

## Test plan
- Bench: behavioural master at SCL = clk/16 with a wired-AND SDA model, plus a checker on rx_valid/rx_data.
- Reset: hold rst high for 3 clk with the bus idle -> all outputs at reset values, sda_pull_low=0.
- Matching write: START, 0xA0 (0x50, W), 0xA5, 0x3C, STOP.
  - Expect 3 ACKs (SDA low at the 9th SCL high each time) and rx_valid twice with rx_data 0xA5 then 0x3C.
  - Expect byte_count=2, stop_seen one pulse, addr_match 1 then 0 after STOP.
- Wrong address: START, 0xA2 (0x51, W), 0x11, STOP -> sda_pull_low never asserts, no rx_valid, addr_match stays 0.
- Read request: START, 0xA1 (0x50, R) -> NACK, state IGNORE; STOP -> IDLE.
- Repeated START: START, 0xA0, 0x77, then 4 bits, then START, 0xA0, 0x99, STOP.
  - Expect rx_data 0x77 then 0x99 only; no rx_valid for the partial byte.
  - byte_count resets at the second START and ends at 1.
- Reset mid-byte: assert rst after bit 5 of a data byte, then release it and run a full write of 0x5A.
  - Expect no spurious rx_valid, sda_pull_low=0 throughout the reset, and the subsequent transaction receives 0x5A correctly.

Source files
------------

// File: rtl/i2c_slave_rx.sv
`timescale 1ns/1ps
// Write-only I2C slave: detects START/STOP, ACKs its own write address, deserialises data bytes.
// Latency: bus events act 3 clk after the raw pin edge; rx_valid/rx_data 3 clk after the 8th SCL rise.
// Backpressure: none; rx_valid is a one-cycle strobe and the slave never stretches SCL.
module i2c_slave_rx #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_pull_low,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_match,
    output logic       stop_seen,
    output logic [7:0] byte_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_DATA,
        S_DATA_ACK,
        S_IGNORE
    } state_t;

    // Synchroniser chain: _m metastable stage, _s synchronised, _p previous for edge detection.
    logic scl_m_q, scl_s_q, scl_p_q, scl_m_d, scl_s_d, scl_p_d;
    logic sda_m_q, sda_s_q, sda_p_q, sda_m_d, sda_s_d, sda_p_d;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;       // bits already received in the current byte
    logic       pull_q, pull_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       addr_match_q, addr_match_d;
    logic       stop_seen_q, stop_seen_d;
    logic [7:0] byte_count_q, byte_count_d;

    logic       scl_rise, scl_fall, start_ev, stop_ev;
    logic [7:0] byte_in;

    // Synchroniser next values: shift the raw pins one stage per clock.
    always_comb begin
        scl_m_d = scl;
        scl_s_d = scl_m_q;
        scl_p_d = scl_s_q;
        sda_m_d = sda_in;
        sda_s_d = sda_m_q;
        sda_p_d = sda_s_q;
    end

    // Bus events; START/STOP qualify on the current synchronised SCL level.
    always_comb begin
        scl_rise = scl_s_q & ~scl_p_q;
        scl_fall = ~scl_s_q & scl_p_q;
        start_ev = scl_s_q & sda_p_q & ~sda_s_q;
        stop_ev  = scl_s_q & ~sda_p_q & sda_s_q;
        byte_in  = {shift_q, sda_s_q};
    end

    // Protocol FSM: START/STOP first, then SCL-edge processing per state.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        pull_d       = 1'b0;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        addr_match_d = addr_match_q;
        stop_seen_d  = 1'b0;
        byte_count_d = byte_count_q;

        if (start_ev) begin
            state_d      = S_ADDR;
            bit_cnt_d    = 3'd0;
            shift_d      = 7'd0;
            byte_count_d = 8'd0;
            addr_match_d = 1'b0;
        end else if (stop_ev) begin
            state_d      = S_IDLE;
            bit_cnt_d    = 3'd0;
            shift_d      = 7'd0;
            addr_match_d = 1'b0;
            stop_seen_d  = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    bit_cnt_d = 3'd0;
                    shift_d   = 7'd0;
                end
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_d = byte_in[6:0];
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = 3'd0;
                            if (byte_in[7:1] == SLAVE_ADDR && !byte_in[0]) begin
                                state_d      = S_ADDR_ACK;
                                addr_match_d = 1'b1;
                            end else begin
                                state_d = S_IGNORE;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                S_ADDR_ACK, S_DATA_ACK: begin
                    // First fall (end of bit 8) grabs SDA, second fall (end of bit 9) lets go.
                    pull_d = pull_q;
                    if (scl_fall) begin
                        if (!pull_q) begin
                            pull_d = 1'b1;
                        end else begin
                            pull_d    = 1'b0;
                            state_d   = S_DATA;
                            bit_cnt_d = 3'd0;
                        end
                    end
                end
                S_DATA: begin
                    if (scl_rise) begin
                        shift_d = byte_in[6:0];
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d  = 3'd0;
                            rx_data_d  = byte_in;
                            rx_valid_d = 1'b1;
                            if (byte_count_q != 8'hFF) begin
                                byte_count_d = byte_count_q + 8'd1;
                            end
                            state_d = S_DATA_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                S_IGNORE: begin
                    bit_cnt_d = 3'd0;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers; synchronisers reset to the idle-bus level.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_m_q      <= 1'b1;
            scl_s_q      <= 1'b1;
            scl_p_q      <= 1'b1;
            sda_m_q      <= 1'b1;
            sda_s_q      <= 1'b1;
            sda_p_q      <= 1'b1;
            state_q      <= S_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 7'd0;
            pull_q       <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            addr_match_q <= 1'b0;
            stop_seen_q  <= 1'b0;
            byte_count_q <= 8'd0;
        end else begin
            scl_m_q      <= scl_m_d;
            scl_s_q      <= scl_s_d;
            scl_p_q      <= scl_p_d;
            sda_m_q      <= sda_m_d;
            sda_s_q      <= sda_s_d;
            sda_p_q      <= sda_p_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            pull_q       <= pull_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            addr_match_q <= addr_match_d;
            stop_seen_q  <= stop_seen_d;
            byte_count_q <= byte_count_d;
        end
    end

    assign sda_pull_low = pull_q;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign addr_match   = addr_match_q;
    assign stop_seen    = stop_seen_q;
    assign byte_count   = byte_count_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
`timescale 1ns/1ps
// Bench for i2c_slave_rx: behavioural I2C master at SCL = clk/16 on a wired-AND SDA line.
// Expected ACKs, received bytes, counts and ACK hold times come from a transaction-level model.
// Directed scenarios first, then randomized write transactions.
module tb_i2c_slave_rx;

    localparam logic [6:0] MY_ADDR = 7'h50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       sda_pull_low;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       addr_match;
    logic       stop_seen;
    logic [7:0] byte_count;

    int tests = 0;
    int fails = 0;

    logic [7:0] got_q[$];
    logic [7:0] tx_q[$];
    int         stop_cnt = 0;
    int         pull_cnt = 0;

    always #5 clk = ~clk;

    assign sda_bus = sda_m & ~sda_pull_low;

    i2c_slave_rx #(.SLAVE_ADDR(MY_ADDR)) dut (
        .clk         (clk),
        .rst         (rst),
        .scl         (scl_m),
        .sda_in      (sda_bus),
        .sda_pull_low(sda_pull_low),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .addr_match  (addr_match),
        .stop_seen   (stop_seen),
        .byte_count  (byte_count)
    );

    // Passive monitor sampled on the falling clock edge.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) got_q.push_back(rx_data);
        if (stop_seen === 1'b1) stop_cnt++;
        if (sda_pull_low === 1'b1) pull_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SCL period starting and ending with SCL low; samples the bus mid-high.
    task automatic bit_cyc(input logic b, output logic sampled);
        tick(4); sda_m = b;
        tick(4); scl_m = 1'b1;
        tick(4); sampled = sda_bus;
        tick(4); scl_m = 1'b0;
    endtask

    task automatic send_start();
        tick(2); sda_m = 1'b1;
        tick(4); scl_m = 1'b1;
        tick(4); sda_m = 1'b0;
        tick(4); scl_m = 1'b0;
    endtask

    task automatic send_stop();
        tick(2); sda_m = 1'b0;
        tick(4); scl_m = 1'b1;
        tick(4); sda_m = 1'b1;
        tick(8);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cyc(b[i], s);
        bit_cyc(1'b1, ack);
    endtask

    // Full transaction: START, header, tx_q data bytes, STOP, then model comparison.
    task automatic run_write(input logic [7:0] hdr, input string tag);
        int   g0, s0, p0, n, exp_n;
        logic ack, matched;
        matched = (hdr[7:1] == MY_ADDR) && (hdr[0] == 1'b0);
        n       = tx_q.size();
        exp_n   = matched ? n : 0;
        g0 = got_q.size(); s0 = stop_cnt; p0 = pull_cnt;
        send_start();
        chk($sformatf("%s bc_at_start", tag), {24'd0, byte_count}, 32'd0);
        send_byte(hdr, ack);
        chk($sformatf("%s hdr_ack", tag), {31'd0, ack}, matched ? 32'd0 : 32'd1);
        chk($sformatf("%s addr_match", tag), {31'd0, addr_match}, {31'd0, matched});
        for (int i = 0; i < n; i++) begin
            send_byte(tx_q[i], ack);
            chk($sformatf("%s data_ack%0d", tag, i), {31'd0, ack}, matched ? 32'd0 : 32'd1);
        end
        send_stop();
        chk($sformatf("%s rx_cnt", tag), got_q.size() - g0, exp_n);
        for (int i = 0; i < exp_n; i++)
            chk($sformatf("%s rx_byte%0d", tag, i), {24'd0, got_q[g0 + i]}, {24'd0, tx_q[i]});
        chk($sformatf("%s byte_count", tag), {24'd0, byte_count}, exp_n);
        chk($sformatf("%s stop_pulses", tag), stop_cnt - s0, 32'd1);
        chk($sformatf("%s addr_after_stop", tag), {31'd0, addr_match}, 32'd0);
        chk($sformatf("%s pull_cycles", tag), pull_cnt - p0, matched ? 16 * (n + 1) : 0);
    endtask

    initial begin
        logic       ack, s;
        logic [7:0] hdr, part;
        int         g0, p0, sel, n;

        // Reset with idle bus.
        rst = 1'b1;
        tick(3);
        @(negedge clk);
        chk("rst pull", {31'd0, sda_pull_low}, 32'd0);
        chk("rst rx_data", {24'd0, rx_data}, 32'd0);
        chk("rst rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst addr_match", {31'd0, addr_match}, 32'd0);
        chk("rst stop_seen", {31'd0, stop_seen}, 32'd0);
        chk("rst byte_count", {24'd0, byte_count}, 32'd0);
        tick(1);
        rst = 1'b0;
        tick(8);

        // Matching write.
        tx_q = '{8'hA5, 8'h3C};
        run_write(8'hA0, "match");

        // Wrong address.
        tx_q = '{8'h11};
        run_write(8'hA2, "wrong_addr");

        // Read request to own address.
        tx_q = '{};
        run_write(8'hA1, "read_req");

        // Repeated START after a full byte plus a partial byte.
        g0 = got_q.size();
        send_start();
        send_byte(8'hA0, ack);
        chk("rs hdr1_ack", {31'd0, ack}, 32'd0);
        send_byte(8'h77, ack);
        chk("rs d1_ack", {31'd0, ack}, 32'd0);
        chk("rs bc1", {24'd0, byte_count}, 32'd1);
        part = 8'hB0;
        for (int i = 7; i >= 4; i--) bit_cyc(part[i], s);
        send_start();
        chk("rs bc_cleared", {24'd0, byte_count}, 32'd0);
        chk("rs addr_cleared", {31'd0, addr_match}, 32'd0);
        send_byte(8'hA0, ack);
        chk("rs hdr2_ack", {31'd0, ack}, 32'd0);
        send_byte(8'h99, ack);
        chk("rs d2_ack", {31'd0, ack}, 32'd0);
        send_stop();
        chk("rs rx_cnt", got_q.size() - g0, 32'd2);
        chk("rs rx0", {24'd0, got_q[g0]}, 32'h77);
        chk("rs rx1", {24'd0, got_q[g0 + 1]}, 32'h99);
        chk("rs bc_end", {24'd0, byte_count}, 32'd1);

        // Reset in the middle of a data byte.
        g0 = got_q.size();
        send_start();
        send_byte(8'hA0, ack);
        chk("mr hdr_ack", {31'd0, ack}, 32'd0);
        part = 8'h5A;
        for (int i = 7; i >= 3; i--) bit_cyc(part[i], s);
        p0 = pull_cnt;
        rst = 1'b1;
        sda_m = 1'b1;
        tick(2);
        scl_m = 1'b1;
        tick(4);
        @(negedge clk);
        chk("mr pull", {31'd0, sda_pull_low}, 32'd0);
        chk("mr addr_match", {31'd0, addr_match}, 32'd0);
        chk("mr byte_count", {24'd0, byte_count}, 32'd0);
        chk("mr rx_data", {24'd0, rx_data}, 32'd0);
        tick(1);
        rst = 1'b0;
        tick(8);
        chk("mr no_rx", got_q.size() - g0, 32'd0);
        chk("mr no_pull", pull_cnt - p0, 32'd0);
        tx_q = '{8'h5A};
        run_write(8'hA0, "after_rst");

        // Randomized transactions.
        for (int t = 0; t < 10; t++) begin
            sel = $urandom_range(0, 3);
            if (sel <= 1) hdr = 8'hA0;
            else if (sel == 2) hdr = 8'hA1;
            else begin
                hdr = 8'($urandom_range(0, 255));
                if (hdr[7:1] == MY_ADDR) hdr[7:1] = MY_ADDR ^ 7'h01;
            end
            n = $urandom_range(0, 4);
            tx_q = '{};
            for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom_range(0, 255)));
            run_write(hdr, $sformatf("rand%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
